// File: rtl/mac_array.sv
// mac_array: NCH-channel multiply-accumulate over DEPTH beats sharing one coefficient stream.
module mac_array #(
   parameter int DW = 8,
   parameter int NCH = 4,
   parameter int DEPTH = 8,
   parameter int AW = 20,
   parameter int SAT = 0,
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_mode,
   input  logic              abort,
   input  logic              in_valid,
   input  logic [DW-1:0]     a_in,
   input  logic [NCH*DW-1:0] x_in,
   output logic [CW-1:0]     coe_addr,
   output logic              busy,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [NCH*AW-1:0] res,
   output logic [NCH-1:0]    ovf
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
   state_t         r_state;
   logic [CW-1:0]  r_step;
   logic [AW-1:0]  r_acc [NCH];
   logic [NCH-1:0] r_ovf;
   logic           r_sm;
   logic [AW-1:0]  w_nxt [NCH];
   logic [NCH-1:0] w_of;
   logic           w_clr;
   logic           w_last;
   assign w_clr     = start && (r_state == IDLE || (r_state == HOLD && res_ready));
   assign w_last    = r_step == CW'(DEPTH - 1);
   assign coe_addr  = (r_state == ACC) ? r_step : '0;
   assign busy      = r_state != IDLE;
   assign res_valid = r_state == HOLD;
   assign ovf       = r_ovf;
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DW-1:0]          w_x;
      logic signed [2*DW-1:0] w_ps;
      logic [2*DW-1:0]        w_pu;
      logic [AW-1:0]          w_p;
      logic [AW:0]            w_sum;
      assign w_x   = x_in[i*DW +: DW];
      assign w_ps  = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{w_x[DW-1]}}, w_x});
      assign w_pu  = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_x};
      assign w_p   = r_sm ? AW'(w_ps) : AW'(w_pu);
      // one guard bit: sign-extended in signed mode, carry in unsigned mode
      assign w_sum = {r_sm & r_acc[i][AW-1], r_acc[i]} + {r_sm & w_p[AW-1], w_p};
      assign w_of[i] = r_sm ? (w_sum[AW] ^ w_sum[AW-1]) : w_sum[AW];
      // a clamped channel stays frozen at its limit for the rest of the run
      assign w_nxt[i] = (SAT != 0 && r_ovf[i]) ? r_acc[i] :
                        (SAT != 0 && w_of[i]) ? (r_sm ? {w_sum[AW], {(AW-1){~w_sum[AW]}}} : '1) :
                        w_sum[AW-1:0];
      assign res[i*AW +: AW] = r_acc[i];
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_ovf   <= '0;
         r_sm    <= 1'b0;
         for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_step  <= '0;
      end else if (w_clr) begin
         r_state <= ACC;
         r_step  <= '0;
         r_ovf   <= '0;
         r_sm    <= signed_mode;
         for (int k = 0; k < NCH; k++) r_acc[k] <= '0;
      end else if (r_state == ACC && in_valid) begin
         for (int k = 0; k < NCH; k++) r_acc[k] <= w_nxt[k];
         r_ovf   <= r_ovf | w_of;
         r_step  <= w_last ? '0 : r_step + 1'b1;
         r_state <= w_last ? HOLD : ACC;
      end else if (r_state == HOLD && res_ready) begin
         r_state <= IDLE;
      end
   end
endmodule

// File: doc/mac_array.md
MAC_ARRAY -- requirements
Module: mac_array

Interface
REQ-001 SHALL have parameter DW, default 8, meaning operand width in bits.
REQ-002 SHALL have parameter NCH, default 4, meaning number of parallel MAC channels.
REQ-003 SHALL have parameter DEPTH, default 8, meaning terms accumulated per result (>=2).
REQ-004 SHALL have parameter AW, default 20, meaning accumulator and result width per channel (>=2*DW).
REQ-005 SHALL have parameter SAT, default 0, meaning 1 = saturating accumulate and 0 = modulo-2^AW wrap.
REQ-006 SHALL have local parameter CW = max(1, clog2(DEPTH)).
REQ-007 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: begin a new accumulation.
REQ-010 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled on the start-accept cycle.
REQ-011 SHALL have port abort, input, 1 bit: synchronous cancel.
REQ-012 SHALL have port in_valid, input, 1 bit: a_in/x_in hold a valid beat.
REQ-013 SHALL have port a_in, input, DW bits: shared coefficient operand.
REQ-014 SHALL have port x_in, input, NCH*DW bits: per-channel operands, channel i at bits [i*DW +: DW].
REQ-015 SHALL have port coe_addr, output, CW bits: index of the coefficient expected on the next accepted beat.
REQ-016 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-017 SHALL have port res_valid, output, 1 bit: results available.
REQ-018 SHALL have port res_ready, input, 1 bit: consumer accepts results.
REQ-019 SHALL have port res, output, NCH*AW bits: per-channel sums, channel i at bits [i*AW +: AW].
REQ-020 SHALL have port ovf, output, NCH bits: per-channel sticky overflow, valid with res.

Function
REQ-021 SHALL implement an FSM with states IDLE, ACC and HOLD.
REQ-022 In IDLE, start=1 SHALL do all of the following: clear accumulators, step counter and ovf; latch signed_mode; go to ACC next cycle; no beat is accepted in this cycle.
REQ-023 In ACC, a beat SHALL be accepted when in_valid=1; each accepted beat adds a_in*x_in[i] to accumulator i and increments step; in_valid=0 SHALL hold all state.
REQ-024 coe_addr SHALL equal step, which SHALL range 0..DEPTH-1; coe_addr SHALL be 0 in IDLE and HOLD.
REQ-025 On the DEPTH-th accepted beat, the FSM SHALL go to HOLD; res_valid=1 in HOLD only.
REQ-026 First res_valid SHALL occur DEPTH+1 cycles after the start-accept edge when in_valid is held at 1.
REQ-027 res and ovf SHALL be held stable while res_valid=1 and res_ready=0.
REQ-028 In HOLD, res_ready=1 SHALL complete the transfer; with start=1 in the same cycle, the FSM SHALL go directly to ACC, performing the REQ-022 clear; otherwise it goes to IDLE.
REQ-029 start SHALL be ignored in ACC, and in HOLD without res_ready.
REQ-030 Each product SHALL be computed at 2*DW bits: signed or unsigned per the latched mode, then sign- or zero-extended to AW.
REQ-031 With SAT=0, the accumulator SHALL wrap modulo 2^AW, and ovf[i] SHALL set if the true sum leaves the representable range.
REQ-032 With SAT=1, the accumulator SHALL clamp to [-2^(AW-1), 2^(AW-1)-1] in signed mode, or to [0, 2^AW-1] in unsigned mode, and set ovf[i]; a saturated value SHALL remain saturated.
REQ-033 abort=1 in any state SHALL return the FSM to IDLE next cycle, drop res_valid and ignore start; abort SHALL take priority over start, in_valid and res_ready.
REQ-034 res SHALL show the live accumulators in ACC and the last results in IDLE until the next start clears them.

Reset
REQ-035 rst=0 SHALL immediately force all of the following: state IDLE, step 0, accumulators 0, ovf 0, latched mode 0, busy 0, res_valid 0, coe_addr 0, res 0; this applies mid-operation too, with no partial result surviving.

Verification
REQ-036 Unsigned case, defaults: a_in=k+1 at beat k, x={ch0=1, ch1=2, ch2=255, ch3=0}, in_valid=1 -> coe_addr steps 0..7, res_valid 9 cycles after start, res={36, 72, 9180, 0}, ovf=0.
REQ-037 Signed case: a_in=0xFF, x ch0=0x80, ch1=0x7F, ch2=0x01, ch3=0x00 for 8 beats -> res ch0=1024, ch1=0xFFC08 (-1016), ch2=0xFFFF8 (-8), ch3=0.
REQ-038 Stall case: REQ-036 stimulus with in_valid=0 on every other cycle -> coe_addr holds during gaps, results identical, res_valid 17 cycles after start.
REQ-039 Overflow case, AW=16, unsigned, a=x=255 for 8 beats -> SAT=1 gives 0xFFFF with ovf=0xF; SAT=0 gives 61448 with ovf=0xF.
REQ-040 Backpressure case: res_ready=0 for 5 cycles in HOLD -> res stable; then res_ready=1 with start=1 -> next cycle ACC with coe_addr=0 and no IDLE cycle.
REQ-041 Cancel case: rst pulsed low, or abort=1, after 4 accepted beats -> IDLE, res_valid=0, and a new start yields a correct fresh result.
